// File: rtl/ar_demux12_stream.sv
// ar_demux12_stream: registered 1-to-N valid/ready demultiplexer with a one-word holding register per channel.
// Define AR_DEMUX_CNT_EN to build the per-channel delivery counters (cnt_clr / cnt_out).
module ar_demux12_stream #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 1,
  parameter int CNT_W = 16,
  localparam int N = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  input  logic               cnt_clr,
  output logic [N*CNT_W-1:0] cnt_out
);

  logic [N-1:0]     buf_vld_reg;
  logic [N-1:0]     buf_vld_next;
  logic [WIDTH-1:0] buf_data_reg  [N];
  logic [WIDTH-1:0] buf_data_next [N];
  logic [N-1:0]     fill;
  logic [N-1:0]     drain;

  // A channel can take a word if it is empty or is emptying this very cycle.
  assign in_ready  = ~buf_vld_reg[sel] | out_ready[sel];
  assign out_valid = buf_vld_reg;
  assign drain     = buf_vld_reg & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign fill[gi]          = in_valid & in_ready & (sel == SEL_W'(gi));
      assign buf_vld_next[gi]  = fill[gi] | (buf_vld_reg[gi] & ~drain[gi]);
      assign buf_data_next[gi] = fill[gi] ? in_data : buf_data_reg[gi];
      assign out_data[gi*WIDTH +: WIDTH] = buf_data_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_vld_reg <= '0;
      for (int i = 0; i < N; i++) begin
        buf_data_reg[i] <= '0;
      end
    end else begin
      buf_vld_reg <= buf_vld_next;
      for (int i = 0; i < N; i++) begin
        buf_data_reg[i] <= buf_data_next[i];
      end
    end
  end

`ifdef AR_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_reg  [N];
  logic [CNT_W-1:0] cnt_next [N];

  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      // Clear wins over a handshake in the same cycle; the add wraps naturally.
      assign cnt_next[gi] = cnt_clr ? '0 : cnt_reg[gi] + CNT_W'(drain[gi]);
      assign cnt_out[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_out        = '0;
`endif

endmodule
